// File: rtl/ysyx_exec_datapath.sv
// Execute datapath for the single-cycle RV32 core: register file, ALU and branch-condition unit.
// Define RF_BYPASS_EN to forward same-cycle write data onto the register read ports.
module ysyx_exec_datapath #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rf_wr_en,
  input  logic [$clog2(NREG)-1:0] waddr,
  input  logic [XLEN-1:0]         wdata,
  input  logic [$clog2(NREG)-1:0] raddr1,
  input  logic [$clog2(NREG)-1:0] raddr2,
  output logic [XLEN-1:0]         rdata1,
  output logic [XLEN-1:0]         rdata2,
  input  logic [XLEN-1:0]         alu_a,
  input  logic [XLEN-1:0]         alu_b,
  input  logic [3:0]              alu_func,
  output logic [XLEN-1:0]         alu_out,
  input  logic [2:0]              br_type,
  output logic                    br_taken
);

  localparam int AW = $clog2(NREG);

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_func_e;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_EQ   = 3'd1,
    BR_NE   = 3'd2,
    BR_LT   = 3'd3,
    BR_GE   = 3'd4,
    BR_LTU  = 3'd5,
    BR_GEU  = 3'd6,
    BR_JUMP = 3'd7
  } br_type_e;

  logic [XLEN-1:0] r_regs [NREG];
  logic [XLEN-1:0] w_stored1;
  logic [XLEN-1:0] w_stored2;
  logic            w_wr_valid;
  logic [4:0]      w_shamt;
  logic            w_lt_signed;
  logic            w_lt_unsigned;
  logic            w_equal;

  // Reset wins over a simultaneous write; x0 is never stored.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_valid) begin
      r_regs[waddr] <= wdata;
    end
  end

  assign w_wr_valid = rf_wr_en && (waddr != '0);
  assign w_stored1  = (raddr1 == '0) ? '0 : r_regs[raddr1];
  assign w_stored2  = (raddr2 == '0) ? '0 : r_regs[raddr2];

`ifdef RF_BYPASS_EN
  // Write-first forwarding, suppressed while reset is asserted.
  assign rdata1 = (!rst && w_wr_valid && (raddr1 == waddr)) ? wdata : w_stored1;
  assign rdata2 = (!rst && w_wr_valid && (raddr2 == waddr)) ? wdata : w_stored2;
`else
  assign rdata1 = w_stored1;
  assign rdata2 = w_stored2;
`endif

  assign w_shamt = alu_b[4:0];

  always_comb begin
    alu_out = '0;
    case (alu_func_e'(alu_func))
      ALU_ADD:   alu_out = alu_a + alu_b;
      ALU_SUB:   alu_out = alu_a - alu_b;
      ALU_SLL:   alu_out = alu_a << w_shamt;
      ALU_SLT:   alu_out = {{(XLEN-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
      ALU_SLTU:  alu_out = {{(XLEN-1){1'b0}}, (alu_a < alu_b)};
      ALU_XOR:   alu_out = alu_a ^ alu_b;
      ALU_SRL:   alu_out = alu_a >> w_shamt;
      ALU_SRA:   alu_out = $unsigned($signed(alu_a) >>> w_shamt);
      ALU_OR:    alu_out = alu_a | alu_b;
      ALU_AND:   alu_out = alu_a & alu_b;
      ALU_PASSB: alu_out = alu_b;
      default:   alu_out = '0;
    endcase
  end

  assign w_equal       = (rdata1 == rdata2);
  assign w_lt_signed   = ($signed(rdata1) < $signed(rdata2));
  assign w_lt_unsigned = (rdata1 < rdata2);

  always_comb begin
    br_taken = 1'b0;
    case (br_type_e'(br_type))
      BR_NONE: br_taken = 1'b0;
      BR_EQ:   br_taken = w_equal;
      BR_NE:   br_taken = !w_equal;
      BR_LT:   br_taken = w_lt_signed;
      BR_GE:   br_taken = !w_lt_signed;
      BR_LTU:  br_taken = w_lt_unsigned;
      BR_GEU:  br_taken = !w_lt_unsigned;
      BR_JUMP: br_taken = 1'b1;
      default: br_taken = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_ysyx_exec_datapath.sv
// Self-checking bench for ysyx_exec_datapath against a behavioural model of registers, ALU and branches.
// Expectations for same-cycle reads follow RF_BYPASS_EN when it is defined for the build.
module tb_ysyx_exec_datapath;

  logic        clk;
  logic        rst;
  logic        rfWrEn;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic [31:0] aluA;
  logic [31:0] aluB;
  logic [3:0]  aluFunc;
  logic [31:0] aluOut;
  logic [2:0]  brType;
  logic        brTaken;

  int errors;
  int checks;
  logic [31:0] modelRegs [32];

  ysyx_exec_datapath #(.XLEN(32), .NREG(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .rf_wr_en (rfWrEn),
    .waddr    (waddr),
    .wdata    (wdata),
    .raddr1   (raddr1),
    .raddr2   (raddr2),
    .rdata1   (rdata1),
    .rdata2   (rdata2),
    .alu_a    (aluA),
    .alu_b    (aluB),
    .alu_func (aluFunc),
    .alu_out  (aluOut),
    .br_type  (brType),
    .br_taken (brTaken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU built on 64-bit integer arithmetic rather than bit-level operators.
  function automatic logic [31:0] refAlu(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
    longint ua;
    longint ub;
    longint sa;
    longint sb;
    int     sh;
    ua = longint'(a);
    ub = longint'(b);
    sa = a[31] ? ua - 64'sh1_0000_0000 : ua;
    sb = b[31] ? ub - 64'sh1_0000_0000 : ub;
    sh = int'(b % 32);
    case (f)
      4'd0:    return 32'(ua + ub);
      4'd1:    return 32'(ua - ub);
      4'd2:    return 32'(ua * (64'sd1 <<< sh));
      4'd3:    return (sa < sb) ? 32'd1 : 32'd0;
      4'd4:    return (ua < ub) ? 32'd1 : 32'd0;
      4'd5:    return a ^ b;
      4'd6:    return 32'(ua / (64'sd1 <<< sh));
      4'd7:    return 32'(sa >>> sh);
      4'd8:    return a | b;
      4'd9:    return a & b;
      4'd10:   return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic refBranch(input logic [2:0] t, input logic [31:0] r1, input logic [31:0] r2);
    longint u1;
    longint u2;
    longint s1;
    longint s2;
    u1 = longint'(r1);
    u2 = longint'(r2);
    s1 = r1[31] ? u1 - 64'sh1_0000_0000 : u1;
    s2 = r2[31] ? u2 - 64'sh1_0000_0000 : u2;
    case (t)
      3'd1:    return u1 == u2;
      3'd2:    return u1 != u2;
      3'd3:    return s1 < s2;
      3'd4:    return s1 >= s2;
      3'd5:    return u1 < u2;
      3'd6:    return u1 >= u2;
      3'd7:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Expected read value for the current cycle, including forwarding when enabled.
  function automatic logic [31:0] refRead(input logic [4:0] ra);
    logic [31:0] v;
    v = (ra == 5'd0) ? 32'd0 : modelRegs[ra];
`ifdef RF_BYPASS_EN
    if (!rst && rfWrEn && waddr != 5'd0 && ra == waddr) v = wdata;
`endif
    return v;
  endfunction

  task automatic writeReg(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    rfWrEn = 1'b1;
    waddr  = a;
    wdata  = d;
    @(posedge clk);
    if (a != 5'd0) modelRegs[a] = d;
    @(negedge clk);
    rfWrEn = 1'b0;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 32; i++) modelRegs[i] = 32'd0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    doReset();
    for (int i = 0; i < 32; i++) begin
      raddr1 = 5'(i);
      raddr2 = 5'(31 - i);
      #1;
      checks++;
      if (rdata1 !== 32'd0) begin
        errors++;
        $display("[TB] FAIL reset_rdata1 idx=%0d got=%h exp=%h", i, rdata1, 32'd0);
      end
      checks++;
      if (rdata2 !== 32'd0) begin
        errors++;
        $display("[TB] FAIL reset_rdata2 idx=%0d got=%h exp=%h", 31 - i, rdata2, 32'd0);
      end
    end
  endtask

  task automatic test_write_read();
    writeReg(5'd5, 32'hDEADBEEF);
    raddr1 = 5'd5;
    #1;
    checks++;
    if (rdata1 !== 32'hDEADBEEF) begin
      errors++;
      $display("[TB] FAIL write_x5 got=%h exp=%h", rdata1, 32'hDEADBEEF);
    end
    writeReg(5'd0, 32'h12345678);
    raddr2 = 5'd0;
    #1;
    checks++;
    if (rdata2 !== 32'd0) begin
      errors++;
      $display("[TB] FAIL write_x0 got=%h exp=%h", rdata2, 32'd0);
    end
  endtask

  task automatic test_reset_collision();
    writeReg(5'd3, 32'h0000_1234);
    @(negedge clk);
    rst    = 1'b1;
    rfWrEn = 1'b1;
    waddr  = 5'd3;
    wdata  = 32'h0000_00FF;
    raddr1 = 5'd3;
    raddr2 = 5'd5;
    #1;
    checks++;
    if (rdata1 !== 32'h0000_1234) begin
      errors++;
      $display("[TB] FAIL collision_pre_edge got=%h exp=%h", rdata1, 32'h0000_1234);
    end
    @(posedge clk);
    for (int i = 0; i < 32; i++) modelRegs[i] = 32'd0;
    @(negedge clk);
    rst    = 1'b0;
    rfWrEn = 1'b0;
    #1;
    checks++;
    if (rdata1 !== 32'd0) begin
      errors++;
      $display("[TB] FAIL collision_x3 got=%h exp=%h", rdata1, 32'd0);
    end
    checks++;
    if (rdata2 !== 32'd0) begin
      errors++;
      $display("[TB] FAIL collision_x5_lost got=%h exp=%h", rdata2, 32'd0);
    end
  endtask

  task automatic test_same_cycle_rw();
    logic [31:0] expSame;
    writeReg(5'd7, 32'h1);
    @(negedge clk);
    rfWrEn = 1'b1;
    waddr  = 5'd7;
    wdata  = 32'h2;
    raddr1 = 5'd7;
    #1;
`ifdef RF_BYPASS_EN
    expSame = 32'h2;
`else
    expSame = 32'h1;
`endif
    checks++;
    if (rdata1 !== expSame) begin
      errors++;
      $display("[TB] FAIL rw_same_cycle got=%h exp=%h", rdata1, expSame);
    end
    @(posedge clk);
    modelRegs[7] = 32'h2;
    @(negedge clk);
    rfWrEn = 1'b0;
    #1;
    checks++;
    if (rdata1 !== 32'h2) begin
      errors++;
      $display("[TB] FAIL rw_after_edge got=%h exp=%h", rdata1, 32'h2);
    end
  endtask

  task automatic test_random_regfile();
    logic [31:0] e1;
    logic [31:0] e2;
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      rfWrEn = 1'($urandom_range(0, 1));
      waddr  = 5'($urandom_range(0, 31));
      wdata  = $urandom;
      raddr1 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
      raddr2 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
      #1;
      e1 = refRead(raddr1);
      e2 = refRead(raddr2);
      checks++;
      if (rdata1 !== e1) begin
        errors++;
        $display("[TB] FAIL rand_rdata1 n=%0d ra=%0d got=%h exp=%h", n, raddr1, rdata1, e1);
      end
      checks++;
      if (rdata2 !== e2) begin
        errors++;
        $display("[TB] FAIL rand_rdata2 n=%0d ra=%0d got=%h exp=%h", n, raddr2, rdata2, e2);
      end
      @(posedge clk);
      if (rfWrEn && waddr != 5'd0) modelRegs[waddr] = wdata;
    end
    @(negedge clk);
    rfWrEn = 1'b0;
  endtask

  task automatic test_alu();
    logic [3:0]  dirFunc [10];
    logic [31:0] dirA    [10];
    logic [31:0] dirB    [10];
    logic [31:0] dirExp  [10];
    logic [31:0] e;
    dirFunc = '{4'd0, 4'd1, 4'd3, 4'd4, 4'd7, 4'd6, 4'd2, 4'd10, 4'd15, 4'd12};
    dirA    = '{32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000,
                32'h80000000, 32'h1, 32'h0, 32'h12345678, 32'hFFFFFFFF};
    dirB    = '{32'h1, 32'h1, 32'h1, 32'h1, 32'h4, 32'h4, 32'd35, 32'hABCDE000,
                32'h9ABCDEF0, 32'hFFFFFFFF};
    dirExp  = '{32'h0, 32'hFFFFFFFF, 32'h1, 32'h0, 32'hF8000000, 32'h08000000,
                32'h8, 32'hABCDE000, 32'h0, 32'h0};
    for (int i = 0; i < 10; i++) begin
      aluFunc = dirFunc[i];
      aluA    = dirA[i];
      aluB    = dirB[i];
      #1;
      checks++;
      if (aluOut !== dirExp[i]) begin
        errors++;
        $display("[TB] FAIL alu_directed func=%0d a=%h b=%h got=%h exp=%h", aluFunc, aluA, aluB, aluOut, dirExp[i]);
      end
    end
    for (int n = 0; n < 96; n++) begin
      aluFunc = 4'(n % 16);
      aluA    = $urandom;
      aluB    = ($urandom_range(0, 3) == 0) ? aluA : $urandom;
      #1;
      e = refAlu(aluFunc, aluA, aluB);
      checks++;
      if (aluOut !== e) begin
        errors++;
        $display("[TB] FAIL alu_random func=%0d a=%h b=%h got=%h exp=%h", aluFunc, aluA, aluB, aluOut, e);
      end
    end
  endtask

  task automatic test_branch();
    logic expDir [8];
    logic e;
    expDir = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    writeReg(5'd1, 32'hFFFFFFFF);
    writeReg(5'd2, 32'h1);
    raddr1 = 5'd1;
    raddr2 = 5'd2;
    for (int t = 0; t < 8; t++) begin
      brType = 3'(t);
      #1;
      checks++;
      if (brTaken !== expDir[t]) begin
        errors++;
        $display("[TB] FAIL branch_directed type=%0d got=%b exp=%b", t, brTaken, expDir[t]);
      end
    end
    writeReg(5'd2, 32'hFFFFFFFF);
    brType = 3'd1;
    #1;
    checks++;
    if (brTaken !== 1'b1) begin
      errors++;
      $display("[TB] FAIL branch_beq_equal got=%b exp=%b", brTaken, 1'b1);
    end
    brType = 3'd2;
    #1;
    checks++;
    if (brTaken !== 1'b0) begin
      errors++;
      $display("[TB] FAIL branch_bne_equal got=%b exp=%b", brTaken, 1'b0);
    end
    for (int n = 0; n < 12; n++) begin
      writeReg(5'd10, $urandom);
      writeReg(5'd11, ($urandom_range(0, 3) == 0) ? modelRegs[10] : $urandom);
      raddr1 = 5'd10;
      raddr2 = 5'd11;
      for (int t = 0; t < 8; t++) begin
        brType = 3'(t);
        #1;
        e = refBranch(brType, modelRegs[10], modelRegs[11]);
        checks++;
        if (brTaken !== e) begin
          errors++;
          $display("[TB] FAIL branch_random type=%0d r1=%h r2=%h got=%b exp=%b", t, modelRegs[10], modelRegs[11], brTaken, e);
        end
      end
    end
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    rst     = 1'b1;
    rfWrEn  = 1'b0;
    waddr   = '0;
    wdata   = '0;
    raddr1  = '0;
    raddr2  = '0;
    aluA    = '0;
    aluB    = '0;
    aluFunc = '0;
    brType  = '0;
    for (int i = 0; i < 32; i++) modelRegs[i] = 32'd0;
    repeat (2) @(negedge clk);
    test_reset();
    test_write_read();
    test_reset_collision();
    test_same_cycle_rw();
    test_random_regfile();
    test_alu();
    test_branch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
